// File: rtl/dly_pkg.sv
// Shared types and constants for the delay arbiter.
// FSM encoding, default unit length and length field width.
package dly_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int T_UNIT_DEF = 1000000;
  localparam int LEN_W      = 4;
  localparam int ID_W       = 3;

endpackage

// File: rtl/dly_if.sv
// Request/completion bundle between requesters and the arbiter.
// The master side posts requests, the slave side serves them.
interface dly_if #(
  parameter int NREQ = 4
);
  import dly_pkg::*;

  logic [NREQ-1:0]       req;
  logic [LEN_W*NREQ-1:0] dly_len;
  logic [NREQ-1:0]       dly_over;
  logic [NREQ-1:0]       pend;
  logic                  busy;
  logic [ID_W-1:0]       gnt_id;

  modport master (
    output req,
    output dly_len,
    input  dly_over,
    input  pend,
    input  busy,
    input  gnt_id
  );

  modport slave (
    input  req,
    input  dly_len,
    output dly_over,
    output pend,
    output busy,
    output gnt_id
  );

endinterface

// File: rtl/dly_unit_timer.sv
// Two-level delay timer: cycles per unit, then units per delay.
// done fires on the last cycle of the final unit.
module dly_unit_timer
  import dly_pkg::*;
#(
  parameter int T_UNIT = T_UNIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [LEN_W-1:0] len,
  output logic             done
);

  localparam int CW = (T_UNIT > 1) ? $clog2(T_UNIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(T_UNIT - 1);

  logic [CW-1:0]    cyc;
  logic [LEN_W-1:0] unit;
  logic [LEN_W-1:0] unit_last;
  logic             wrap;

  assign unit_last = len - LEN_W'(1);
  assign wrap      = run && (cyc == CYC_LAST);
  assign done      = wrap && (unit == unit_last);

  // unit returns to zero on completion so it never exceeds len-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= '0;
      unit <= '0;
    end else if (start) begin
      cyc  <= '0;
      unit <= '0;
    end else if (wrap) begin
      cyc  <= '0;
      unit <= done ? '0 : unit + LEN_W'(1);
    end else if (run) begin
      cyc  <= cyc + CW'(1);
    end
  end

endmodule

// File: rtl/dly_arbiter.sv
// Round-robin arbiter sharing one delay timer among NREQ requesters.
// Edge-triggered requests, pending flags, IDLE/ARB/RUN/DONE FSM.
module dly_arbiter
  import dly_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int T_UNIT = T_UNIT_DEF
) (
  input logic  clk,
  input logic  rst_n,
  dly_if.slave bus
);

  state_t state;
  state_t state_nx;

  logic [NREQ-1:0]  req_q;
  logic [NREQ-1:0]  armed;
  logic [NREQ-1:0]  rise;
  logic [NREQ-1:0]  pend_q;
  logic [NREQ-1:0]  gmask;
  logic [NREQ-1:0]  over;
  logic [ID_W-1:0]  gnt_q;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  cand;
  logic [LEN_W-1:0] len_raw;
  logic [LEN_W-1:0] len_sel;
  logic [LEN_W-1:0] len_q;
  logic             any_pend;
  logic             start;
  logic             run;
  logic             done;
  logic             busy;

  // a level held through reset must drop before it can post again
  assign rise     = bus.req & ~req_q & armed;
  assign any_pend = |pend_q;

  // farthest candidate first so the nearest pending one wins
  always_comb begin
    sel  = gnt_q;
    cand = gnt_q;
    for (int k = NREQ; k >= 1; k--) begin
      cand = ID_W'((int'(gnt_q) + k) % NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (pend_q[i] && (cand == ID_W'(i)))
          sel = ID_W'(i);
      end
    end
  end

  always_comb begin
    len_raw = '0;
    gmask   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == ID_W'(i))
        len_raw = bus.dly_len[LEN_W*i +: LEN_W];
      gmask[i] = (state == ARB) && (sel == ID_W'(i));
    end
    len_sel = (len_raw == '0) ? LEN_W'(1) : len_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      armed  <= '0;
      pend_q <= '0;
      gnt_q  <= ID_W'(NREQ - 1);
      len_q  <= LEN_W'(1);
    end else begin
      req_q  <= bus.req;
      armed  <= armed | ~bus.req;
      pend_q <= (pend_q & ~gmask) | rise;
      if (state == ARB) begin
        gnt_q <= sel;
        len_q <= len_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (any_pend) state_nx = ARB;
      ARB:  state_nx = any_pend ? RUN : IDLE;
      RUN:  if (done) state_nx = DONE;
      DONE: state_nx = any_pend ? ARB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    run   = (state == RUN);
    start = (state == ARB) && any_pend;
    over  = '0;
    for (int i = 0; i < NREQ; i++)
      over[i] = (state == DONE) && (gnt_q == ID_W'(i));
  end

  dly_unit_timer #(
    .T_UNIT(T_UNIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .run  (run),
    .len  (len_q),
    .done (done)
  );

  assign bus.dly_over = over;
  assign bus.pend     = pend_q;
  assign bus.busy     = busy;
  assign bus.gnt_id   = gnt_q;

endmodule

// File: tb/tb_dly_arbiter.sv
// Bench for dly_arbiter: timestamp model plus directed scenarios.
// T_UNIT = 10, NREQ = 4.
module tb_dly_arbiter;
  import dly_pkg::*;

  localparam int NREQ = 4;
  localparam int TU   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dly_if #(.NREQ(NREQ)) bus ();

  dly_arbiter #(
    .NREQ  (NREQ),
    .T_UNIT(TU)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, want, $time);
    end
  endtask

  // model: cycle index and timestamps of the current/next service
  int m_t;
  int m_gnt;
  int m_arb_at;
  int m_run_beg;
  int m_run_end;
  int m_done_at;
  logic [NREQ-1:0] m_pend;
  logic [NREQ-1:0] m_prev;
  logic [NREQ-1:0] m_seen0;

  task automatic m_reset();
    m_t       = 0;
    m_gnt     = NREQ - 1;
    m_arb_at  = -1;
    m_run_beg = 0;
    m_run_end = -1;
    m_done_at = -1;
    m_pend    = '0;
    m_prev    = '0;
    m_seen0   = '0;
  endtask

  task automatic m_step();
    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] gm;
    int n;
    int g;
    int len;
    n    = m_t;
    rise = bus.req & ~m_prev & m_seen0;
    gm   = '0;
    if (n == m_arb_at) begin
      g = m_gnt;
      for (int k = NREQ; k >= 1; k--)
        if (m_pend[(m_gnt + k) % NREQ]) g = (m_gnt + k) % NREQ;
      len = int'(bus.dly_len[4*g +: 4]);
      if (len == 0) len = 1;
      gm[g]     = 1'b1;
      m_gnt     = g;
      m_run_beg = n + 1;
      m_run_end = n + len * TU;
      m_done_at = m_run_end + 1;
      m_arb_at  = -1;
    end else if (n == m_done_at) begin
      if (m_pend != 0) m_arb_at = n + 1;
    end else if (n > m_done_at && m_arb_at < 0 && m_pend != 0) begin
      m_arb_at = n + 1;
    end
    m_pend  = (m_pend & ~gm) | rise;
    m_seen0 = m_seen0 | ~bus.req;
    m_prev  = bus.req;
    m_t     = n + 1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // per-cycle compare plus completion log
  int busy_cnt = 0;
  int cyc      = 0;
  int over_q[$];
  int over_t[$];

  initial begin
    logic [NREQ-1:0] e_over;
    forever begin
      @(negedge clk);
      cyc++;
      e_over = '0;
      if (m_t == m_done_at) e_over[m_gnt] = 1'b1;
      chk("pend", 32'(bus.pend), 32'(m_pend));
      chk("busy", 32'(bus.busy),
          32'(m_t >= m_run_beg && m_t <= m_run_end));
      chk("dly_over", 32'(bus.dly_over), 32'(e_over));
      chk("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
      chk("over_onehot", 32'($countones(bus.dly_over) <= 1), 32'd1);
      if (bus.busy) busy_cnt++;
      for (int i = 0; i < NREQ; i++)
        if (bus.dly_over[i]) begin
          over_q.push_back(i);
          over_t.push_back(cyc);
        end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    busy_cnt = 0;
    over_q.delete();
    over_t.delete();
  endtask

  task automatic pulse(input int i);
    bus.req[i] = 1'b1;
    tick();
    bus.req[i] = 1'b0;
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int q = 0;
    int n = 0;
    while (q < 3 && n < budget) begin
      tick();
      n++;
      if (!bus.busy && bus.pend == 0 && bus.dly_over == 0) q++;
      else q = 0;
    end
    chk(nm, 32'(q), 32'd3);
  endtask

  task automatic wait_busy(input string nm, output int lat);
    lat = 0;
    while (!bus.busy && lat < 40) begin
      tick();
      lat++;
    end
    chk(nm, 32'(bus.busy), 32'd1);
  endtask

  function automatic int qid(input int k);
    return (k < over_q.size()) ? over_q[k] : 99;
  endfunction

  function automatic int qgap(input int k);
    return (k + 1 < over_t.size()) ? over_t[k+1] - over_t[k] : -1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.req     = '0;
    bus.dly_len = '0;
    rst_n       = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);
    chk("rst_over", 32'(bus.dly_over), 32'd0);
    chk("rst_gnt", 32'(bus.gnt_id), 32'd3);
    rst_n = 1'b1;
    repeat (3) tick();

    // simultaneous requests, all length 1
    clr();
    bus.dly_len = 16'h1111;
    bus.req     = 4'b1011;
    tick();
    bus.req     = '0;
    wait_quiet("sim_quiet", 200);
    chk("sim_cnt", 32'(over_q.size()), 32'd3);
    chk("sim_id0", 32'(qid(0)), 32'd0);
    chk("sim_id1", 32'(qid(1)), 32'd1);
    chk("sim_id2", 32'(qid(2)), 32'd3);
    chk("sim_gap0", 32'(qgap(0)), 32'd12);
    chk("sim_gap1", 32'(qgap(1)), 32'd12);
    chk("sim_busy", 32'(busy_cnt), 32'd30);

    // single request, length changed mid-run
    clr();
    bus.dly_len = 16'h0300;
    pulse(2);
    lat = 1;
    while (!bus.busy && lat < 20) begin
      tick();
      lat++;
    end
    chk("one_latency", 32'(lat), 32'd3);
    repeat (10) tick();
    bus.dly_len[11:8] = 4'd7;
    wait_quiet("one_quiet", 100);
    chk("one_busy", 32'(busy_cnt), 32'd30);
    chk("one_cnt", 32'(over_q.size()), 32'd1);
    chk("one_id", 32'(qid(0)), 32'd2);
    chk("one_gnt", 32'(bus.gnt_id), 32'd2);

    // zero and maximum length
    clr();
    bus.dly_len = 16'h0000;
    pulse(1);
    wait_quiet("zero_quiet", 100);
    chk("zero_busy", 32'(busy_cnt), 32'd10);
    chk("zero_id", 32'(qid(0)), 32'd1);
    clr();
    bus.dly_len = 16'h00F0;
    pulse(1);
    wait_quiet("max_quiet", 300);
    chk("max_busy", 32'(busy_cnt), 32'd150);
    chk("max_id", 32'(qid(0)), 32'd1);

    // fairness: 0 re-posts during its own run while 3 waits
    clr();
    bus.dly_len = 16'h2222;
    pulse(0);
    wait_busy("fair_busy", lat);
    pulse(3);
    repeat (3) tick();
    pulse(0);
    wait_quiet("fair_quiet", 300);
    chk("fair_cnt", 32'(over_q.size()), 32'd3);
    chk("fair_id0", 32'(qid(0)), 32'd0);
    chk("fair_id1", 32'(qid(1)), 32'd3);
    chk("fair_id2", 32'(qid(2)), 32'd0);

    // reset in the fifth run cycle
    clr();
    bus.dly_len = 16'h0002;
    pulse(0);
    wait_busy("abort_busy", lat);
    pulse(2);
    repeat (3) tick();
    chk("abort_run5", 32'(busy_cnt), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("abort_busy0", 32'(bus.busy), 32'd0);
    chk("abort_pend0", 32'(bus.pend), 32'd0);
    chk("abort_over0", 32'(bus.dly_over), 32'd0);
    chk("abort_gnt", 32'(bus.gnt_id), 32'd3);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    chk("abort_nover", 32'(over_q.size()), 32'd0);

    // level hold across several delay lengths
    clr();
    bus.dly_len = 16'h1111;
    bus.req[1]  = 1'b1;
    repeat (45) tick();
    chk("hold_cnt1", 32'(over_q.size()), 32'd1);
    bus.req[1] = 1'b0;
    tick();
    bus.req[1] = 1'b1;
    tick();
    wait_quiet("hold_quiet", 100);
    chk("hold_cnt2", 32'(over_q.size()), 32'd2);
    chk("hold_id", 32'(qid(1)), 32'd1);
    bus.req[1] = 1'b0;
    tick();

    // request level held through reset posts nothing
    clr();
    bus.req[3] = 1'b1;
    rst_n      = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("rhold_cnt", 32'(over_q.size()), 32'd0);
    chk("rhold_pend", 32'(bus.pend), 32'd0);
    bus.req[3] = 1'b0;
    tick();
    pulse(3);
    wait_quiet("rhold_quiet", 100);
    chk("rhold_cnt2", 32'(over_q.size()), 32'd1);
    chk("rhold_id", 32'(qid(0)), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
